systolic_skew_feeder: RTL and testbench

Input skewing stage placed directly upstream of the PE array inside `top`. It accepts one N-lane activation column per beat from the on-chip input buffer and re-times lane i by i extra cycles, producing the diagonal wavefront the systolic array needs. The `top` controller issues `start` per tile and waits on `done`. After the last column, the block drains the skew pipeline and reports the accepted beat count.

---
 rtl/systolic_skew_feeder_pkg.sv | 11 +
 rtl/systolic_skew_feeder_delay_line.sv | 29 ++
 rtl/systolic_skew_feeder.sv | 62 ++++++
 tb/tb_systolic_skew_feeder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// systolic_skew_feeder_pkg: FSM encoding and default array geometry shared with the PE array
package systolic_skew_feeder_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;
  localparam int DEF_N  = 4;
  localparam int DEF_DW = 8;
endpackage

// File: rtl/systolic_skew_feeder_delay_line.sv
// skew_delay_line: {valid,data} shift register of DEPTH stages, advancing every cycle
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);
  logic [DEPTH-1:0]         v;
  logic [DEPTH-1:0][DW-1:0] d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v <= '0;
      d <= '0;
    end else begin
      v[0] <= in_valid;
      d[0] <= in_data;
      for (int k = 1; k < DEPTH; k++) begin
        v[k] <= v[k-1];
        d[k] <= d[k-1];
      end
    end
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: delays lane i by i cycles to form the PE array's diagonal input wavefront
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic          in_last,
  output logic [N*DW-1:0] out_data,
  output logic [N-1:0]  out_valid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] beat_count
);
  localparam int DCW = N > 1 ? $clog2(N) : 1;
  state_t         state, next;
  logic [DCW-1:0] dcnt;
  logic           accept;
  assign in_ready = state == STREAM;
  assign accept   = in_valid && in_ready;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = start ? STREAM : IDLE;
      STREAM:  next = accept && in_last ? (N > 1 ? DRAIN : DONE) : STREAM;
      DRAIN:   next = dcnt == DCW'(N - 2) ? DONE : DRAIN;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      dcnt       <= '0;
      beat_count <= '0;
    end else begin
      state <= next;
      dcnt  <= state == DRAIN ? dcnt + 1'b1 : '0;
      if (state == IDLE && start) beat_count <= '0;
      else if (accept && beat_count != '1) beat_count <= beat_count + 1'b1;
    end
  // Non-accepted slots inject zeros so invalid outputs always carry data 0
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(.DEPTH(i + 1), .DW(DW)) u_line (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept),
      .in_data   (accept ? in_data[i*DW +: DW] : '0),
      .out_valid (out_valid[i]),
      .out_data  (out_data[i*DW +: DW])
    );
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: random and directed tiles checked by a cycle-stamped scoreboard
module tb_systolic_skew_feeder;
  localparam int N = 4, DW = 8, CW = 4, BMAX = (1 << CW) - 1;
  typedef struct packed { int cyc; logic [DW-1:0] d; } ent_t;
  logic clk = 0, rst = 0, start = 0, in_valid = 0, in_last = 0;
  logic [N*DW-1:0] in_data = '0;
  logic in_ready, busy, done;
  logic [N*DW-1:0] out_data;
  logic [N-1:0] out_valid;
  logic [CW-1:0] beat_count;
  systolic_skew_feeder #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .done(done), .beat_count(beat_count)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int nchk = 0, nerr = 0;
  ent_t lq[N][$];
  int dq[$];
  bit m_stream = 0, mon_en = 0;
  int m_busy_until = -1, m_count = 0;
  logic exp_ready, exp_busy;
  int exp_count;
  logic ev, edn;
  logic [DW-1:0] ed;
  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    for (int i = 0; i < N; i++) begin
      ev = 0;
      ed = '0;
      if (lq[i].size() > 0 && lq[i][0].cyc == cyc) begin
        ev = 1;
        ed = lq[i][0].d;
        void'(lq[i].pop_front());
      end
      chk($sformatf("lane%0d_valid", i), out_valid[i], ev);
      chk($sformatf("lane%0d_data", i), out_data[i*DW +: DW], ed);
    end
    edn = dq.size() > 0 && dq[0] == cyc;
    if (edn) void'(dq.pop_front());
    chk("done", done, edn);
    chk("in_ready", in_ready, exp_ready);
    chk("busy", busy, exp_busy);
    chk("beat_count", beat_count, exp_count);
  end
  // Model: a beat seen while streaming at cycle p shows on lane i at p+1+i; done at p+N
  task automatic cycle(input logic st, input logic v, input logic last, input logic [N*DW-1:0] data);
    int p;
    logic acc;
    @(posedge clk);
    #1;
    p = cyc;
    start = st; in_valid = v; in_last = last; in_data = data;
    exp_ready = m_stream;
    exp_busy  = m_stream || p <= m_busy_until;
    exp_count = m_count;
    acc = v && m_stream;
    if (!exp_busy && st) begin
      m_stream = 1;
      m_count  = 0;
    end
    if (acc) begin
      for (int i = 0; i < N; i++) lq[i].push_back('{cyc: p + 1 + i, d: data[i*DW +: DW]});
      m_count = m_count < BMAX ? m_count + 1 : BMAX;
      if (last) begin
        m_stream = 0;
        m_busy_until = p + N;
        dq.push_back(p + N);
      end
    end
    mon_en = 1;
  endtask
  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 1'($urandom % 2), $urandom);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_beat_count"}, beat_count, 0);
  endtask
  task automatic mid_reset();
    @(posedge clk);
    #2;
    mon_en = 0;
    rst = 0; in_valid = 1; in_data = 32'hDEADBEEF; start = 1; in_last = 0;
    #1 check_zero("rst_async");
    @(posedge clk);
    #1 check_zero("rst_held");
    for (int i = 0; i < N; i++) lq[i].delete();
    dq.delete();
    m_stream = 0; m_busy_until = -1; m_count = 0;
    @(negedge clk);
    rst = 1; start = 0; in_valid = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst = 1;
    cycle(1, 0, 0, $urandom);
    cycle(0, 1, 0, 32'h04030201);
    cycle(0, 1, 0, 32'h08070605);
    cycle(0, 1, 1, 32'h0C0B0A09);
    idle(8);
    cycle(1, 0, 0, $urandom);
    cycle(0, 1, 0, 32'h04030201);
    cycle(0, 0, 1, $urandom);
    cycle(0, 1, 0, 32'h08070605);
    cycle(0, 1, 1, 32'h0C0B0A09);
    idle(8);
    cycle(1, 0, 0, $urandom);
    cycle(0, 1, 1, 32'hAABBCCDD);
    idle(6);
    cycle(1, 0, 0, $urandom);
    cycle(0, 1, 0, $urandom);
    cycle(1, 1, 0, $urandom);
    cycle(0, 1, 1, $urandom);
    cycle(1, 1, 0, $urandom);
    cycle(1, 1, 1, $urandom);
    idle(6);
    cycle(1, 0, 0, $urandom);
    for (int k = 0; k < 20; k++) cycle(0, 1, 1'(k == 19), $urandom);
    idle(8);
    cycle(1, 0, 0, $urandom);
    cycle(0, 1, 0, $urandom);
    cycle(0, 1, 0, $urandom);
    mid_reset();
    idle(6);
    cycle(1, 0, 0, $urandom);
    cycle(0, 1, 1, $urandom);
    idle(6);
    repeat (600) cycle(1'($urandom % 4 == 0), 1'($urandom % 10 < 7), 1'($urandom % 8 == 0), $urandom);
    idle(12);
    for (int i = 0; i < N; i++) chk($sformatf("lane%0d_pending", i), lq[i].size(), 0);
    chk("done_pending", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
